// File: rtl/hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_controller_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        RUN       = 1'b0,
        MISS_WAIT = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] FWD_RF  = 2'b00;
    localparam logic [SEL_W-1:0] FWD_MEM = 2'b01;
    localparam logic [SEL_W-1:0] FWD_WB  = 2'b10;

    // One bit per pipeline stage register, IF through WB.
    typedef struct packed {
        logic f;
        logic d;
        logic e;
        logic m;
        logic w;
    } stage_ctrl_t;

endpackage

// File: rtl/hazard_controller_forward_unit.sv
// EX-stage operand bypass selection; the younger MEM result wins over WB.
module forward_unit
    import hazard_controller_pkg::*;
(
    input  logic [REG_W-1:0] reg1_srcE,
    input  logic [REG_W-1:0] reg2_srcE,
    input  logic [REG_W-1:0] reg_dstM,
    input  logic [REG_W-1:0] reg_dstW,
    input  logic             reg_write_enM,
    input  logic             reg_write_enW,
    output logic [SEL_W-1:0] op1_sel,
    output logic [SEL_W-1:0] op2_sel
);

    logic mem_ok;
    logic wb_ok;

    always_comb begin
        mem_ok = reg_write_enM && (reg_dstM != '0);
        wb_ok  = reg_write_enW && (reg_dstW != '0);

        op1_sel = FWD_RF;
        if (mem_ok && (reg_dstM == reg1_srcE))     op1_sel = FWD_MEM;
        else if (wb_ok && (reg_dstW == reg1_srcE)) op1_sel = FWD_WB;

        op2_sel = FWD_RF;
        if (mem_ok && (reg_dstM == reg2_srcE))     op2_sel = FWD_MEM;
        else if (wb_ok && (reg_dstW == reg2_srcE)) op2_sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: stage hold/clear controls, bypass selects, D-cache miss freeze
// and saturating performance counters for the 5-stage RV32I core.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned MISS_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] reg1_srcD,
    input  logic [REG_W-1:0] reg2_srcD,
    input  logic [REG_W-1:0] reg1_srcE,
    input  logic [REG_W-1:0] reg2_srcE,
    input  logic [REG_W-1:0] reg_dstE,
    input  logic [REG_W-1:0] reg_dstM,
    input  logic [REG_W-1:0] reg_dstW,
    input  logic             reg_write_enE,
    input  logic             reg_write_enM,
    input  logic             reg_write_enW,
    input  logic             cache_read_enE,
    input  logic             jalD,
    input  logic             jalrE,
    input  logic             br_takenE,
    input  logic             mem_req,
    input  logic             mem_miss,
    input  logic             mem_ready,
    output logic             bubbleF,
    output logic             bubbleD,
    output logic             bubbleE,
    output logic             bubbleM,
    output logic             bubbleW,
    output logic             flushF,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic [SEL_W-1:0] op1_sel,
    output logic [SEL_W-1:0] op2_sel,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             miss_timeout
);

    localparam int unsigned WAIT_W = $clog2(MISS_TIMEOUT + 1);

    state_t            state;
    state_t            state_next;
    stage_ctrl_t       bubble;
    stage_ctrl_t       flush;
    logic              miss_now;
    logic              miss_stall;
    logic              load_use;
    logic              redirect;
    logic [SEL_W-1:0]  fwd1;
    logic [SEL_W-1:0]  fwd2;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_inc;

    forward_unit u_forward_unit (
        .reg1_srcE     (reg1_srcE),
        .reg2_srcE     (reg2_srcE),
        .reg_dstM      (reg_dstM),
        .reg_dstW      (reg_dstW),
        .reg_write_enM (reg_write_enM),
        .reg_write_enW (reg_write_enW),
        .op1_sel       (fwd1),
        .op2_sel       (fwd2)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    // Next state and stage controls; priority: reset, miss freeze, redirect, load-use, jal.
    always_comb begin
        state_next = state;
        bubble     = '0;
        flush      = '0;
        op1_sel    = fwd1;
        op2_sel    = fwd2;
        miss_now   = mem_req && mem_miss;
        miss_stall = (state == MISS_WAIT) || miss_now;
        redirect   = br_takenE || jalrE;
        load_use   = cache_read_enE && (reg_dstE != '0) &&
                     ((reg_dstE == reg1_srcD) || (reg_dstE == reg2_srcD));

        case (state)
            RUN:       if (miss_now)  state_next = MISS_WAIT;
            MISS_WAIT: if (mem_ready) state_next = RUN;
            default:   state_next = RUN;
        endcase

        if (rst) begin
            flush   = '1;
            op1_sel = FWD_RF;
            op2_sel = FWD_RF;
        end else if (miss_stall) begin
            bubble.f = 1'b1;
            bubble.d = 1'b1;
            bubble.e = 1'b1;
            bubble.m = 1'b1;
            flush.w  = 1'b1;
        end else if (redirect) begin
            flush.d = 1'b1;
            flush.e = 1'b1;
        end else if (load_use) begin
            bubble.f = 1'b1;
            bubble.d = 1'b1;
            flush.e  = 1'b1;
        end else if (jalD) begin
            flush.d = 1'b1;
        end
    end

    assign {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW} = bubble;
    assign {flushF, flushD, flushE, flushM, flushW}      = flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if ((bubble != '0) && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if ((flush.d || flush.e) && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

    assign wait_inc = wait_cnt + WAIT_W'(1);

    // Miss watchdog: the flag is sticky, the FSM keeps waiting for the refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt     <= '0;
            miss_timeout <= 1'b0;
        end else if (state == RUN) begin
            if (miss_now) wait_cnt <= '0;
        end else begin
            if (wait_cnt != WAIT_W'(MISS_TIMEOUT)) wait_cnt <= wait_inc;
            if (wait_inc == WAIT_W'(MISS_TIMEOUT)) miss_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed plus random checks of hazard_controller against a cycle-level behavioural model.
module tb_hazard_controller;

    localparam int CW  = 6;
    localparam int MT  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic [4:0]    reg1_srcD, reg2_srcD, reg1_srcE, reg2_srcE;
    logic [4:0]    reg_dstE, reg_dstM, reg_dstW;
    logic          reg_write_enE, reg_write_enM, reg_write_enW;
    logic          cache_read_enE, jalD, jalrE, br_takenE;
    logic          mem_req, mem_miss, mem_ready;
    logic          bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
    logic          flushF, flushD, flushE, flushM, flushW;
    logic [1:0]    op1_sel, op2_sel;
    logic [CW-1:0] stall_cycles, flush_count;
    logic          miss_timeout;

    int total = 0;
    int bad   = 0;

    bit m_waiting = 0;
    int m_wcnt    = 0;
    bit m_to      = 0;
    int m_stall   = 0;
    int m_flush   = 0;
    bit m_valid   = 0;
    int s0;

    hazard_controller #(.CNT_W(CW), .MISS_TIMEOUT(MT)) dut (
        .clk(clk), .rst(rst),
        .reg1_srcD(reg1_srcD), .reg2_srcD(reg2_srcD),
        .reg1_srcE(reg1_srcE), .reg2_srcE(reg2_srcE),
        .reg_dstE(reg_dstE), .reg_dstM(reg_dstM), .reg_dstW(reg_dstW),
        .reg_write_enE(reg_write_enE), .reg_write_enM(reg_write_enM),
        .reg_write_enW(reg_write_enW),
        .cache_read_enE(cache_read_enE), .jalD(jalD), .jalrE(jalrE),
        .br_takenE(br_takenE),
        .mem_req(mem_req), .mem_miss(mem_miss), .mem_ready(mem_ready),
        .bubbleF(bubbleF), .bubbleD(bubbleD), .bubbleE(bubbleE),
        .bubbleM(bubbleM), .bubbleW(bubbleW),
        .flushF(flushF), .flushD(flushD), .flushE(flushE),
        .flushM(flushM), .flushW(flushW),
        .op1_sel(op1_sel), .op2_sel(op2_sel),
        .stall_cycles(stall_cycles), .flush_count(flush_count),
        .miss_timeout(miss_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fwd(input logic [4:0] src);
        if (reg_write_enM && reg_dstM != 0 && reg_dstM == src) return 1;
        if (reg_write_enW && reg_dstW != 0 && reg_dstW == src) return 2;
        return 0;
    endfunction

    task automatic idle();
        {reg1_srcD, reg2_srcD, reg1_srcE, reg2_srcE} = '0;
        {reg_dstE, reg_dstM, reg_dstW} = '0;
        {reg_write_enE, reg_write_enM, reg_write_enW} = '0;
        {cache_read_enE, jalD, jalrE, br_takenE} = '0;
        {mem_req, mem_miss, mem_ready} = '0;
    endtask

    // Check one cycle at the falling edge, then advance the model across the rising edge.
    task automatic cyc();
        logic [4:0] eb, ef;
        bit ms, lu, rd;
        @(negedge clk);
        ms = m_waiting || (mem_req && mem_miss);
        rd = br_takenE || jalrE;
        lu = cache_read_enE && reg_dstE != 0 &&
             (reg_dstE == reg1_srcD || reg_dstE == reg2_srcD);
        eb = 5'b0;
        ef = 5'b0;
        if (rst) ef = 5'b11111;
        else if (ms) begin eb = 5'b11110; ef = 5'b00001; end
        else if (rd) ef = 5'b01100;
        else if (lu) begin eb = 5'b11000; ef = 5'b00100; end
        else if (jalD) ef = 5'b01000;

        chk("bubble", 32'({bubbleF, bubbleD, bubbleE, bubbleM, bubbleW}), 32'(eb));
        chk("flush", 32'({flushF, flushD, flushE, flushM, flushW}), 32'(ef));
        if (rst) begin
            chk("rst_op1", 32'(op1_sel), 32'(0));
            chk("rst_op2", 32'(op2_sel), 32'(0));
        end else if (!ms) begin
            chk("op1_sel", 32'(op1_sel), 32'(fwd(reg1_srcE)));
            chk("op2_sel", 32'(op2_sel), 32'(fwd(reg2_srcE)));
        end
        if (m_valid) begin
            chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
            chk("flush_count", 32'(flush_count), 32'(m_flush));
            chk("miss_timeout", 32'(miss_timeout), 32'(m_to));
        end

        if (rst) begin
            m_waiting = 0; m_wcnt = 0; m_to = 0; m_stall = 0; m_flush = 0; m_valid = 1;
        end else begin
            if (eb != 0) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
            if (ef[3] || ef[2]) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
            if (!m_waiting) begin
                if (mem_req && mem_miss) begin m_waiting = 1; m_wcnt = 0; end
            end else begin
                m_wcnt++;
                if (m_wcnt >= MT) m_to = 1;
                if (mem_ready) m_waiting = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("post_rst_stall", 32'(stall_cycles), 32'(0));
        chk("post_rst_to", 32'(miss_timeout), 32'(0));

        // Load-use, then the load in MEM feeds EX
        reg_write_enE = 1; cache_read_enE = 1; reg_dstE = 5; reg1_srcD = 5;
        #1;
        chk("lu_bubbleF", 32'(bubbleF), 32'(1));
        chk("lu_flushE", 32'(flushE), 32'(1));
        cyc();
        idle();
        reg_dstM = 5; reg_write_enM = 1; reg1_srcE = 5;
        #1;
        chk("lu_fwd_mem", 32'(op1_sel), 32'(1));
        chk("lu_released", 32'(bubbleF), 32'(0));
        cyc();

        // Forwarding priority and x0
        idle();
        reg_dstM = 7; reg_dstW = 7; reg_write_enM = 1; reg_write_enW = 1; reg2_srcE = 7;
        #1; chk("fwd_mem_over_wb", 32'(op2_sel), 32'(1)); cyc();
        reg_dstM = 0;
        #1; chk("fwd_wb", 32'(op2_sel), 32'(2)); cyc();
        reg_dstW = 0; reg2_srcE = 0;
        #1; chk("fwd_x0", 32'(op2_sel), 32'(0)); cyc();

        // Branch redirect and jal under load-use
        idle();
        s0 = int'(flush_count);
        br_takenE = 1;
        #1; chk("br_flushD", 32'(flushD), 32'(1)); cyc();
        idle();
        #1; chk("br_count", 32'(flush_count), 32'(s0 + 1));
        jalD = 1; cache_read_enE = 1; reg_dstE = 3; reg2_srcD = 3;
        #1; chk("jal_lu_flushD", 32'(flushD), 32'(0)); cyc();
        cache_read_enE = 0;
        #1; chk("jal_retry_flushD", 32'(flushD), 32'(1)); cyc();

        // Miss for five frozen cycles
        idle();
        s0 = int'(stall_cycles);
        mem_req = 1; mem_miss = 1;
        cyc();
        idle();
        repeat (3) cyc();
        mem_ready = 1;
        #1; chk("miss_last_frozen", 32'(bubbleM), 32'(1)); cyc();
        idle();
        #1;
        chk("miss_release", 32'(bubbleF), 32'(0));
        chk("miss_stall_cnt", 32'(stall_cycles), 32'(s0 + 5));
        cyc();

        // Timeout, then reset out of MISS_WAIT
        mem_req = 1; mem_miss = 1;
        cyc();
        idle();
        repeat (8) cyc();
        chk("timeout_set", 32'(miss_timeout), 32'(1));
        rst = 1;
        cyc();
        rst = 0;
        #1;
        chk("timeout_clr", 32'(miss_timeout), 32'(0));
        chk("rst_to_run", 32'(bubbleF), 32'(0));
        cyc();

        // Saturation through a long freeze
        mem_req = 1; mem_miss = 1;
        cyc();
        idle();
        repeat (70) cyc();
        mem_ready = 1;
        cyc();
        idle();
        #1; chk("stall_saturated", 32'(stall_cycles), 32'(SAT));
        rst = 1;
        cyc();
        rst = 0;

        // Random traffic with a narrow register range to provoke matches
        repeat (1500) begin
            reg1_srcD      = 5'($urandom_range(0, 3));
            reg2_srcD      = 5'($urandom_range(0, 3));
            reg1_srcE      = 5'($urandom_range(0, 3));
            reg2_srcE      = 5'($urandom_range(0, 3));
            reg_dstE       = 5'($urandom_range(0, 3));
            reg_dstM       = 5'($urandom_range(0, 3));
            reg_dstW       = 5'($urandom_range(0, 3));
            reg_write_enE  = 1'($urandom_range(0, 1));
            reg_write_enM  = 1'($urandom_range(0, 1));
            reg_write_enW  = 1'($urandom_range(0, 1));
            cache_read_enE = ($urandom_range(0, 2) == 0);
            jalD           = ($urandom_range(0, 5) == 0);
            jalrE          = ($urandom_range(0, 7) == 0);
            br_takenE      = ($urandom_range(0, 7) == 0);
            mem_req        = 1'($urandom_range(0, 1));
            mem_miss       = ($urandom_range(0, 5) == 0);
            mem_ready      = ($urandom_range(0, 3) == 0);
            rst            = ($urandom_range(0, 99) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
